// File: rtl/cpu_stim_pkg.sv
// Shared constants for the CPU clock-step stimulus generator.
//  MODE_*  : encodings of the 2-bit mode input
//  state_t : controller FSM state encoding
package cpu_stim_pkg;

    localparam logic [1:0] MODE_FREE  = 2'd0;
    localparam logic [1:0] MODE_STEP  = 2'd1;
    localparam logic [1:0] MODE_BURST = 2'd2;
    localparam logic [1:0] MODE_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BURST = 2'd3
    } state_t;

endpackage

// File: rtl/cpu_step_stim_gen_prescaler.sv
// Modulo-DIV prescaler with a terminal-count tick.
//  clk, rst_n : clock, async active-low reset
//  i_en       : advance the count this cycle
//  i_clr      : synchronous restart at 0 (wins over i_en)
//  o_tick_c   : high in the cycle the count wraps (DIV-1 -> 0), combinational
module clk_prescaler #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick_c
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick_c = i_en && !i_clr && (r_cnt == TERM);

    // Free counter 0..DIV-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == TERM) ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/cpu_step_stim_gen.sv
// CPU clock-step and selector stimulus controller.
// Derives a slow registered cpu_clk from clk in free-run, single-step or burst
// mode, and drives a loadable / auto-incrementing selector bus.
//  clk, rst_n    : system clock, async active-low reset
//  mode          : 0 FREE, 1 STEP, 2 BURST, 3 HOLD
//  step_req      : start pulse for STEP / BURST (ignored while busy)
//  burst_len     : CPU cycles per burst, sampled at start (0 acts as 1)
//  sel_auto      : enable selector auto-increment
//  sel_load      : load sel_load_val into sel (priority over auto)
//  sel_load_val  : selector load value
//  cpu_clk       : derived CPU clock
//  cpu_rise      : one-cycle pulse with each 0->1 transition of cpu_clk
//  busy          : controller not idle
//  sel           : selector bus
//  cycle_cnt     : wrapping count of cpu_clk rising edges
module cpu_step_stim_gen
    import cpu_stim_pkg::*;
#(
    parameter int unsigned SEL_W    = 5,
    parameter int unsigned SEL_DIV  = 1,
    parameter int unsigned HALF_DIV = 10,
    parameter int unsigned BURST_W  = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         mode,
    input  logic               step_req,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               sel_auto,
    input  logic               sel_load,
    input  logic [SEL_W-1:0]   sel_load_val,
    output logic               cpu_clk,
    output logic               cpu_rise,
    output logic               busy,
    output logic [SEL_W-1:0]   sel,
    output logic [CNT_W-1:0]   cycle_cnt
);

    state_t             r_state;
    logic               r_cpu_clk;
    logic               r_cpu_rise;
    logic               r_busy;
    logic [CNT_W-1:0]   r_cycle_cnt;
    logic [BURST_W-1:0] r_rem;
    logic [SEL_W-1:0]   r_sel;

    logic w_active;
    logic w_half_tick;
    logic w_sel_tick;

    assign w_active = (r_state != ST_IDLE);

    // Half-period divider: held at 0 in IDLE so every entry starts a fresh period
    clk_prescaler #(.DIV(HALF_DIV)) u_half_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (w_active),
        .i_clr    (!w_active),
        .o_tick_c (w_half_tick)
    );

    // Selector divider: frozen when auto is off, restarted by a load
    clk_prescaler #(.DIV(SEL_DIV)) u_sel_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (sel_auto),
        .i_clr    (sel_load),
        .o_tick_c (w_sel_tick)
    );

    // Controller FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cpu_clk   <= 1'b0;
            r_cpu_rise  <= 1'b0;
            r_busy      <= 1'b0;
            r_cycle_cnt <= '0;
            r_rem       <= '0;
        end else begin
            r_cpu_rise <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cpu_clk <= 1'b0;
                    case (mode)
                        MODE_FREE: begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end
                        MODE_STEP: begin
                            if (step_req) begin
                                r_state <= ST_STEP;
                                r_busy  <= 1'b1;
                            end
                        end
                        MODE_BURST: begin
                            if (step_req) begin
                                r_state <= ST_BURST;
                                r_busy  <= 1'b1;
                                r_rem   <= (burst_len == '0) ? BURST_W'(1) : burst_len;
                            end
                        end
                        MODE_HOLD: begin
                        end
                    endcase
                end
                default: begin
                    if (w_half_tick) begin
                        if (!r_cpu_clk) begin
                            r_cpu_clk   <= 1'b1;
                            r_cpu_rise  <= 1'b1;
                            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
                        end else begin
                            // Falling edge closes a full CPU period; exits happen only here
                            r_cpu_clk <= 1'b0;
                            case (r_state)
                                ST_RUN: begin
                                    if (mode != MODE_FREE) begin
                                        r_state <= ST_IDLE;
                                        r_busy  <= 1'b0;
                                    end
                                end
                                ST_STEP: begin
                                    r_state <= ST_IDLE;
                                    r_busy  <= 1'b0;
                                end
                                ST_BURST: begin
                                    r_rem <= r_rem - BURST_W'(1);
                                    if (r_rem <= BURST_W'(1)) begin
                                        r_state <= ST_IDLE;
                                        r_busy  <= 1'b0;
                                    end
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    // Selector bus: load has priority over auto-increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= '0;
        end else if (sel_load) begin
            r_sel <= sel_load_val;
        end else if (w_sel_tick) begin
            r_sel <= r_sel + SEL_W'(1);
        end
    end

    assign cpu_clk   = r_cpu_clk;
    assign cpu_rise  = r_cpu_rise;
    assign busy      = r_busy;
    assign sel       = r_sel;
    assign cycle_cnt = r_cycle_cnt;

endmodule
